// File: rtl/frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : frame_receiver
//  Description : RX-side consumer of the gigabit MAC client interface for the
//                delay tester. Parses each received frame, recognises test
//                frames by EtherType, extracts a big-endian 32-bit sequence
//                number (bytes 14-17) and transmit timestamp (bytes 18-21),
//                and on good-frame status produces the one-way delay
//                (now_time - timestamp) plus a sequence-continuity flag.
//                Keeps good/bad/test frame counters.
//  Option      : FRAME_RECEIVER_STATS_EN - when defined, min_delay/max_delay
//                track delay extremes; otherwise both are constant 0.
//  Ports       : rx_clk, reset          - clock, sync active-high reset
//                conf_rx_en             - receive enable, sampled at frame start
//                mac_rx_data/dvld       - MAC RX byte stream
//                mac_rx_goodframe/bad.. - MAC end-of-frame status pulses
//                now_time               - local time base
//                stats_clr              - clears counters and delay extremes
//                delay_valid/value      - delay result pulse and value
//                seq_num, seq_err       - last sequence number, gap flag
//                good_cnt/bad_cnt/test_cnt, min_delay/max_delay - statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_receiver #(
    parameter logic [15:0] TEST_ETHERTYPE = 16'h88B5
) (
    input  logic        rx_clk,
    input  logic        reset,
    input  logic        conf_rx_en,
    input  logic [7:0]  mac_rx_data,
    input  logic        mac_rx_dvld,
    input  logic        mac_rx_goodframe,
    input  logic        mac_rx_badframe,
    input  logic [31:0] now_time,
    input  logic        stats_clr,
    output logic        delay_valid,
    output logic [31:0] delay_value,
    output logic [31:0] seq_num,
    output logic        seq_err,
    output logic [31:0] good_cnt,
    output logic [31:0] bad_cnt,
    output logic [31:0] test_cnt,
    output logic [31:0] min_delay,
    output logic [31:0] max_delay
);

    localparam logic [2:0]  c_ST_IDLE   = 3'd0;
    localparam logic [2:0]  c_ST_HDR    = 3'd1;
    localparam logic [2:0]  c_ST_BODY   = 3'd2;
    localparam logic [2:0]  c_ST_STATUS = 3'd3;
    localparam logic [2:0]  c_ST_DROP   = 3'd4;
    localparam logic [10:0] c_IDX_MAX   = 11'd2047;
    localparam logic [10:0] c_IDX_LAST  = 11'd21;

    logic [2:0]  r_state;
    logic [10:0] r_idx;
    logic        r_dvld_d;
    logic        r_hdr_done;
    logic [15:0] r_ethertype;
    logic [31:0] r_seq;
    logic [31:0] r_ts;
    logic [31:0] r_seq_exp;
    logic        r_seq_seen;

    logic        r_delay_valid;
    logic [31:0] r_delay_value;
    logic [31:0] r_seq_num;
    logic        r_seq_err;
    logic [31:0] r_good_cnt;
    logic [31:0] r_bad_cnt;
    logic [31:0] r_test_cnt;

    logic        w_in_frame;
    logic        w_status_cycle;
    logic        w_pulse;
    logic        w_handle;
    logic        w_good;
    logic        w_is_test;
    logic        w_accept_good;
    logic        w_accept_test;
    logic        w_missing_status;
    logic        w_bad_inc;
    logic        w_start;
    logic [31:0] w_delay;
    logic [10:0] w_idx_next;

    always_comb begin
        w_in_frame       = (r_state == c_ST_HDR) || (r_state == c_ST_BODY);
        // Status may arrive in the first dvld-low cycle itself, so that cycle
        // is treated as a status cycle to sustain one-cycle inter-frame gaps.
        w_status_cycle   = (w_in_frame && !mac_rx_dvld) || (r_state == c_ST_STATUS);
        w_pulse          = mac_rx_goodframe || mac_rx_badframe;
        w_handle         = w_status_cycle && w_pulse;
        // Both pulses together count as a bad frame.
        w_good           = mac_rx_goodframe && !mac_rx_badframe;
        w_is_test        = r_hdr_done && (r_ethertype == TEST_ETHERTYPE);
        w_accept_good    = w_handle && w_good;
        w_accept_test    = w_accept_good && w_is_test;
        w_missing_status = (r_state == c_ST_STATUS) && mac_rx_dvld && !w_pulse;
        w_bad_inc        = (w_handle && !w_good) || w_missing_status;
        // A new frame begins on a dvld rise in IDLE, or any dvld in STATUS
        // (STATUS is only ever entered with dvld low).
        w_start          = ((r_state == c_ST_IDLE) && mac_rx_dvld && !r_dvld_d) ||
                           ((r_state == c_ST_STATUS) && mac_rx_dvld);
        w_delay          = now_time - r_ts;
        w_idx_next       = (r_idx == c_IDX_MAX) ? r_idx : r_idx + 11'd1;
    end

    always_ff @(posedge rx_clk) begin
        // Tracked through reset so a frame in flight at reset release is
        // recognised as not-a-rise and dropped.
        r_dvld_d <= mac_rx_dvld;
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_idx         <= '0;
            r_hdr_done    <= 1'b0;
            r_ethertype   <= '0;
            r_seq         <= '0;
            r_ts          <= '0;
            r_seq_exp     <= '0;
            r_seq_seen    <= 1'b0;
            r_delay_valid <= 1'b0;
            r_delay_value <= '0;
            r_seq_num     <= '0;
            r_seq_err     <= 1'b0;
            r_good_cnt    <= '0;
            r_bad_cnt     <= '0;
            r_test_cnt    <= '0;
        end else begin
            r_delay_valid <= 1'b0;
            r_seq_err     <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (mac_rx_dvld && r_dvld_d) begin
                        r_state <= c_ST_DROP;
                    end
                end
                c_ST_HDR: begin
                    if (mac_rx_dvld) begin
                        r_idx <= w_idx_next;
                        if (r_idx == 11'd12) r_ethertype[15:8] <= mac_rx_data;
                        if (r_idx == 11'd13) r_ethertype[7:0]  <= mac_rx_data;
                        if (r_idx >= 11'd14 && r_idx <= 11'd17)
                            r_seq <= {r_seq[23:0], mac_rx_data};
                        if (r_idx >= 11'd18 && r_idx <= c_IDX_LAST)
                            r_ts <= {r_ts[23:0], mac_rx_data};
                        if (r_idx == c_IDX_LAST) begin
                            r_hdr_done <= 1'b1;
                            r_state    <= c_ST_BODY;
                        end
                    end else begin
                        r_state <= w_pulse ? c_ST_IDLE : c_ST_STATUS;
                    end
                end
                c_ST_BODY: begin
                    if (mac_rx_dvld) begin
                        r_idx <= w_idx_next;
                    end else begin
                        r_state <= w_pulse ? c_ST_IDLE : c_ST_STATUS;
                    end
                end
                c_ST_STATUS: begin
                    if (w_pulse) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_DROP: begin
                    if (!mac_rx_dvld) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase

            // Frame start consumes byte 0 in the same cycle.
            if (w_start) begin
                r_idx       <= 11'd1;
                r_hdr_done  <= 1'b0;
                r_ethertype <= '0;
                r_state     <= conf_rx_en ? c_ST_HDR : c_ST_DROP;
            end

            if (w_accept_test) begin
                r_delay_valid <= 1'b1;
                r_delay_value <= w_delay;
                r_seq_num     <= r_seq;
                r_seq_err     <= r_seq_seen && (r_seq != r_seq_exp);
                r_seq_exp     <= r_seq + 32'd1;
                r_seq_seen    <= 1'b1;
            end

            r_good_cnt <= r_good_cnt + {31'd0, w_accept_good};
            r_test_cnt <= r_test_cnt + {31'd0, w_accept_test};
            r_bad_cnt  <= r_bad_cnt  + {31'd0, w_bad_inc};

            // Clear wins over any same-cycle increment or sequence update.
            if (stats_clr) begin
                r_good_cnt <= '0;
                r_test_cnt <= '0;
                r_bad_cnt  <= '0;
                r_seq_seen <= 1'b0;
            end
        end
    end

`ifdef FRAME_RECEIVER_STATS_EN
    logic [31:0] r_min_delay;
    logic [31:0] r_max_delay;

    always_ff @(posedge rx_clk) begin
        if (reset || stats_clr) begin
            r_min_delay <= 32'hFFFF_FFFF;
            r_max_delay <= '0;
        end else if (w_accept_test) begin
            if (w_delay < r_min_delay) r_min_delay <= w_delay;
            if (w_delay > r_max_delay) r_max_delay <= w_delay;
        end
    end

    assign min_delay = r_min_delay;
    assign max_delay = r_max_delay;
`else
    assign min_delay = '0;
    assign max_delay = '0;
`endif

    assign delay_valid = r_delay_valid;
    assign delay_value = r_delay_value;
    assign seq_num     = r_seq_num;
    assign seq_err     = r_seq_err;
    assign good_cnt    = r_good_cnt;
    assign bad_cnt     = r_bad_cnt;
    assign test_cnt    = r_test_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_receiver
//  Description : Directed self-checking bench for frame_receiver. Drives
//                frames byte by byte on the falling edge and checks results
//                on the falling edge against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_receiver;

    logic        clk;
    logic        rst;
    logic        conf_rx_en;
    logic [7:0]  mac_rx_data;
    logic        mac_rx_dvld;
    logic        mac_rx_goodframe;
    logic        mac_rx_badframe;
    logic [31:0] now_time;
    logic        stats_clr;
    logic        delay_valid;
    logic [31:0] delay_value;
    logic [31:0] seq_num;
    logic        seq_err;
    logic [31:0] good_cnt;
    logic [31:0] bad_cnt;
    logic [31:0] test_cnt;
    logic [31:0] min_delay;
    logic [31:0] max_delay;

    int total;
    int bad;

    localparam logic [15:0] c_ET = 16'h88B5;

    frame_receiver #(.TEST_ETHERTYPE(c_ET)) u_dut (
        .rx_clk           (clk),
        .reset            (rst),
        .conf_rx_en       (conf_rx_en),
        .mac_rx_data      (mac_rx_data),
        .mac_rx_dvld      (mac_rx_dvld),
        .mac_rx_goodframe (mac_rx_goodframe),
        .mac_rx_badframe  (mac_rx_badframe),
        .now_time         (now_time),
        .stats_clr        (stats_clr),
        .delay_valid      (delay_valid),
        .delay_value      (delay_value),
        .seq_num          (seq_num),
        .seq_err          (seq_err),
        .good_cnt         (good_cnt),
        .bad_cnt          (bad_cnt),
        .test_cnt         (test_cnt),
        .min_delay        (min_delay),
        .max_delay        (max_delay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fb(input int i, input logic [15:0] et,
                                      input logic [31:0] s, input logic [31:0] t);
        logic [31:0] iv;
        iv = i;
        if (i == 12) return et[15:8];
        if (i == 13) return et[7:0];
        if (i >= 14 && i <= 17) return s[8*(17-i) +: 8];
        if (i >= 18 && i <= 21) return t[8*(21-i) +: 8];
        return iv[7:0];
    endfunction

    // st: 0 good, 1 bad, 2 both, 3 no status. lat: idle cycles before status.
    // en_byte >= 0: conf_rx_en low at start, raised from that byte on.
    task automatic send_frame(input int len, input logic [15:0] et,
                              input logic [31:0] s, input logic [31:0] t,
                              input logic [31:0] nt, input int st,
                              input int lat, input int en_byte);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (en_byte >= 0) conf_rx_en = (i >= en_byte);
            mac_rx_dvld = 1'b1;
            mac_rx_data = fb(i, et, s, t);
        end
        @(negedge clk);
        mac_rx_dvld = 1'b0;
        mac_rx_data = 8'h00;
        conf_rx_en  = 1'b1;
        if (st != 3) begin
            repeat (lat) @(negedge clk);
            mac_rx_goodframe = (st == 0) || (st == 2);
            mac_rx_badframe  = (st == 1) || (st == 2);
            now_time         = nt;
            @(negedge clk);
            mac_rx_goodframe = 1'b0;
            mac_rx_badframe  = 1'b0;
        end
    endtask

    task automatic chk_stats(input string tag, input logic [31:0] mn, input logic [31:0] mx);
`ifdef FRAME_RECEIVER_STATS_EN
        chk({tag, "_min"}, min_delay, mn);
        chk({tag, "_max"}, max_delay, mx);
`else
        chk({tag, "_min"}, min_delay, 32'h0);
        chk({tag, "_max"}, max_delay, 32'h0);
`endif
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst              = 1'b1;
        conf_rx_en       = 1'b1;
        mac_rx_data      = 8'h00;
        mac_rx_dvld      = 1'b0;
        mac_rx_goodframe = 1'b0;
        mac_rx_badframe  = 1'b0;
        now_time         = 32'h0;
        stats_clr        = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_dv",   {31'd0, delay_valid}, 32'd0);
        chk("rst_dval", delay_value, 32'd0);
        chk("rst_seq",  seq_num, 32'd0);
        chk("rst_err",  {31'd0, seq_err}, 32'd0);
        chk("rst_good", good_cnt, 32'd0);
        chk("rst_bad",  bad_cnt, 32'd0);
        chk("rst_test", test_cnt, 32'd0);
        chk_stats("rst", 32'hFFFF_FFFF, 32'd0);

        // Basic test frame: 350 - 100 = 250
        send_frame(64, c_ET, 32'd5, 32'd100, 32'd350, 0, 0, -1);
        chk("f1_dv",   {31'd0, delay_valid}, 32'd1);
        chk("f1_dval", delay_value, 32'd250);
        chk("f1_seq",  seq_num, 32'd5);
        chk("f1_err",  {31'd0, seq_err}, 32'd0);
        chk("f1_test", test_cnt, 32'd1);
        chk("f1_good", good_cnt, 32'd1);
        @(negedge clk);
        chk("f1_dv_pulse", {31'd0, delay_valid}, 32'd0);
        chk("f1_dval_hold", delay_value, 32'd250);

        // Sequence 6 (ok), 8 (gap), 9 (ok: expected became 9); status one cycle late on last
        send_frame(64, c_ET, 32'd6, 32'd100, 32'd140, 0, 0, -1);
        chk("f2_dval", delay_value, 32'd40);
        chk("f2_err",  {31'd0, seq_err}, 32'd0);
        send_frame(64, c_ET, 32'd8, 32'd200, 32'd210, 0, 0, -1);
        chk("f3_dv",   {31'd0, delay_valid}, 32'd1);
        chk("f3_dval", delay_value, 32'd10);
        chk("f3_err",  {31'd0, seq_err}, 32'd1);
        send_frame(64, c_ET, 32'd9, 32'd100, 32'd170, 0, 1, -1);
        chk("f4_dv",   {31'd0, delay_valid}, 32'd1);
        chk("f4_dval", delay_value, 32'd70);
        chk("f4_err",  {31'd0, seq_err}, 32'd0);
        chk("f4_good", good_cnt, 32'd4);
        chk("f4_test", test_cnt, 32'd4);
        chk_stats("f4", 32'd10, 32'd250);

        // Bad frame, then both pulses together
        send_frame(64, c_ET, 32'd10, 32'd0, 32'd999, 1, 0, -1);
        chk("f5_dv",   {31'd0, delay_valid}, 32'd0);
        chk("f5_bad",  bad_cnt, 32'd1);
        chk("f5_dval_hold", delay_value, 32'd70);
        send_frame(64, c_ET, 32'd10, 32'd0, 32'd999, 2, 0, -1);
        chk("f6_dv",   {31'd0, delay_valid}, 32'd0);
        chk("f6_bad",  bad_cnt, 32'd2);
        chk("f6_good", good_cnt, 32'd4);

        // Timestamp wrap: 0x10 - 0xFFFFFFF0 = 0x20
        send_frame(64, c_ET, 32'd10, 32'hFFFF_FFF0, 32'h0000_0010, 0, 0, -1);
        chk("f7_dval", delay_value, 32'd32);
        chk("f7_err",  {31'd0, seq_err}, 32'd0);
        chk("f7_test", test_cnt, 32'd5);

        // 20-byte runt with matching EtherType: good only
        send_frame(20, c_ET, 32'd11, 32'd0, 32'd5, 0, 0, -1);
        chk("f8_dv",   {31'd0, delay_valid}, 32'd0);
        chk("f8_good", good_cnt, 32'd6);
        chk("f8_test", test_cnt, 32'd5);

        // Missing status, next frame after a 1-cycle gap is still processed
        send_frame(64, c_ET, 32'd11, 32'd0, 32'd0, 3, 0, -1);
        send_frame(64, c_ET, 32'd11, 32'd0, 32'd5, 0, 0, -1);
        chk("f10_bad",  bad_cnt, 32'd3);
        chk("f10_dv",   {31'd0, delay_valid}, 32'd1);
        chk("f10_dval", delay_value, 32'd5);
        chk("f10_err",  {31'd0, seq_err}, 32'd0);
        chk("f10_good", good_cnt, 32'd7);

        // Disabled at start, enabled mid-frame: ignored
        send_frame(64, c_ET, 32'd12, 32'd0, 32'd77, 0, 0, 5);
        chk("f11_dv",   {31'd0, delay_valid}, 32'd0);
        chk("f11_good", good_cnt, 32'd7);
        chk("f11_test", test_cnt, 32'd6);
        chk("f11_bad",  bad_cnt, 32'd3);

        // Statistics clear
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        chk("clr_good", good_cnt, 32'd0);
        chk("clr_bad",  bad_cnt, 32'd0);
        chk("clr_test", test_cnt, 32'd0);
        chk_stats("clr", 32'hFFFF_FFFF, 32'd0);

        // Delays 40, 10, 70; first after clear never flags
        send_frame(64, c_ET, 32'd100, 32'd0,  32'd40,  0, 0, -1);
        chk("s1_err", {31'd0, seq_err}, 32'd0);
        send_frame(64, c_ET, 32'd101, 32'd50, 32'd60,  0, 0, -1);
        send_frame(64, c_ET, 32'd102, 32'd30, 32'd100, 0, 0, -1);
        chk("s3_dval", delay_value, 32'd70);
        chk("s3_err",  {31'd0, seq_err}, 32'd0);
        chk("s3_test", test_cnt, 32'd3);
        chk_stats("s3", 32'd10, 32'd70);

        // Reset asserted mid-frame with dvld high
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            mac_rx_dvld = 1'b1;
            mac_rx_data = fb(i, c_ET, 32'd200, 32'd0);
            rst         = (i == 10);
            if (i == 11) begin
                chk("mr_good", good_cnt, 32'd0);
                chk("mr_test", test_cnt, 32'd0);
                chk("mr_seq",  seq_num, 32'd0);
                chk("mr_dval", delay_value, 32'd0);
                chk_stats("mr", 32'hFFFF_FFFF, 32'd0);
            end
        end
        @(negedge clk);
        mac_rx_dvld      = 1'b0;
        mac_rx_goodframe = 1'b1;
        now_time         = 32'd500;
        @(negedge clk);
        mac_rx_goodframe = 1'b0;
        chk("mr_end_dv",   {31'd0, delay_valid}, 32'd0);
        chk("mr_end_good", good_cnt, 32'd0);

        // Next frame processed normally
        send_frame(64, c_ET, 32'd50, 32'd1000, 32'd1234, 0, 0, -1);
        chk("f15_dv",   {31'd0, delay_valid}, 32'd1);
        chk("f15_dval", delay_value, 32'd234);
        chk("f15_seq",  seq_num, 32'd50);
        chk("f15_err",  {31'd0, seq_err}, 32'd0);
        chk("f15_good", good_cnt, 32'd1);
        chk("f15_test", test_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
